// File: rtl/tff_toggle_ctrl_if.sv
// tff_toggle_ctrl_if: command handshake between a host and the tff toggle sequencer
//   cmd_valid/cmd_ready : valid/ready handshake, ready only while the sequencer is idle
//   cmd_clr             : 1 = clear the tff, count/gap ignored
//   cmd_count           : number of t pulses to issue
//   cmd_gap             : idle cycles between consecutive t pulses
//   abort               : cancel the command in flight
interface tff_toggle_ctrl_if #(parameter int CNT_W = 8, parameter int GAP_W = 4);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_clr;
  logic [CNT_W-1:0] cmd_count;
  logic [GAP_W-1:0] cmd_gap;
  logic             abort;
  modport master(output cmd_valid, cmd_clr, cmd_count, cmd_gap, abort, input cmd_ready);
  modport slave(input cmd_valid, cmd_clr, cmd_count, cmd_gap, abort, output cmd_ready);
endinterface

// File: rtl/tff_toggle_ctrl.sv
// tff_toggle_ctrl: sequences t pulses and clears for one tff and checks its q against a prediction
//   i_clk      : clock, all state changes on the rising edge
//   i_rst_n    : asynchronous active-low reset
//   cmd        : command handshake (slave side)
//   i_q        : tff.q fed back
//   o_t        : drive to tff.t
//   o_tff_rst  : drive to tff.rst, active-high
//   o_q_exp    : predicted tff state
//   o_busy     : sequencer not idle
//   o_done     : one-cycle pulse on normal completion
//   o_mismatch : sticky, i_q differed from o_q_exp
module tff_toggle_ctrl #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  tff_toggle_ctrl_if.slave    cmd,
  input  logic                i_q,
  output logic                o_t,
  output logic                o_tff_rst,
  output logic                o_q_exp,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_mismatch
);
  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_TOGGLE, S_GAP, S_FIN} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_rem;
  logic [GAP_W-1:0] r_gap_reload;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_q_exp;
  logic             r_mismatch;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_CLEAR;
      r_rem        <= '0;
      r_gap_reload <= '0;
      r_gap_cnt    <= '0;
      r_q_exp      <= 1'b0;
      r_mismatch   <= 1'b0;
    end else begin
      if (r_state != S_CLEAR && i_q != r_q_exp) r_mismatch <= 1'b1;
      case (r_state)
        S_CLEAR: begin
          r_q_exp    <= 1'b0;
          r_mismatch <= 1'b0;
          r_state    <= S_IDLE;
        end
        S_IDLE: if (cmd.cmd_valid) begin
          r_rem        <= cmd.cmd_count;
          r_gap_reload <= cmd.cmd_gap;
          r_state      <= cmd.cmd_clr ? S_CLEAR : cmd.cmd_count == '0 ? S_FIN : S_TOGGLE;
        end
        // the tff samples t=1 on this edge, so the prediction flips even when aborting
        S_TOGGLE: begin
          r_q_exp   <= ~r_q_exp;
          r_rem     <= r_rem - 1'b1;
          r_gap_cnt <= r_gap_reload;
          r_state   <= cmd.abort ? S_IDLE : r_rem == CNT_W'(1) ? S_FIN :
                       r_gap_reload == '0 ? S_TOGGLE : S_GAP;
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt - 1'b1;
          r_state   <= cmd.abort ? S_IDLE : r_gap_cnt == GAP_W'(1) ? S_TOGGLE : S_GAP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign cmd.cmd_ready = r_state == S_IDLE;
  assign o_t           = r_state == S_TOGGLE;
  assign o_tff_rst     = r_state == S_CLEAR;
  assign o_busy        = r_state != S_IDLE;
  assign o_done        = r_state == S_FIN;
  assign o_q_exp       = r_q_exp;
  assign o_mismatch    = r_mismatch;
endmodule

// File: tb/tb_tff_toggle_ctrl.sv
// tb_tff_toggle_ctrl: directed bench with a per-cycle plan model of tff_toggle_ctrl
module tb_tff_toggle_ctrl;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;
  localparam int P_T = 0, P_G = 1, P_D = 2, P_C = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic q_tff = 1'b0;
  logic q_force = 1'b0;
  logic q_in;
  logic t, tff_rst, q_exp, busy, done, mismatch;
  int checks = 0;
  int errors = 0;
  int plan[$];
  logic m_q = 1'b0;
  logic m_mis = 1'b0;
  tff_toggle_ctrl_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) cif ();
  tff_toggle_ctrl #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .cmd(cif), .i_q(q_in), .o_t(t), .o_tff_rst(tff_rst),
    .o_q_exp(q_exp), .o_busy(busy), .o_done(done), .o_mismatch(mismatch)
  );
  always #5 clk = ~clk;
  always @(posedge clk) q_tff <= tff_rst ? 1'b0 : q_tff ^ t;
  assign q_in = q_tff ^ q_force;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic clr, input int cnt, input int gap);
    int k = 0;
    while (!cif.cmd_ready && k < 50) begin
      step();
      k++;
    end
    chk("ready_wait", int'(k < 50), 1);
    cif.cmd_valid = 1'b1;
    cif.cmd_clr   = clr;
    cif.cmd_count = cnt[CNT_W-1:0];
    cif.cmd_gap   = gap[GAP_W-1:0];
    step();
    cif.cmd_valid = 1'b0;
    cif.cmd_clr   = 1'b0;
  endtask
  task automatic run(output int n, output int pat, output int dn);
    n = 0;
    pat = 0;
    dn = 0;
    while (busy && n < 100) begin
      pat = (pat << 1) | int'(t);
      dn += int'(done);
      n++;
      step();
    end
    chk("busy_bound", int'(n < 100), 1);
  endtask
  // model: the command expands into a per-cycle plan (t pulse, gap, done, clear); empty plan = idle
  initial begin
    int h;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        plan = {P_C};
        m_q = 1'b0;
        m_mis = 1'b0;
      end
      h = plan.size() != 0 ? plan[0] : -1;
      chk("outputs", {cif.cmd_ready, t, tff_rst, busy, done, q_exp, mismatch},
          {plan.size() == 0, h == P_T, h == P_C, plan.size() != 0, h == P_D, m_q, m_mis});
      if (rst_n) begin
        if (h != P_C && q_in != m_q) m_mis = 1'b1;
        if (h == P_C) begin
          m_q = 1'b0;
          m_mis = 1'b0;
        end
        if (h == P_T) m_q = ~m_q;
        if (h < 0) begin
          if (cif.cmd_valid) begin
            if (cif.cmd_clr) plan.push_back(P_C);
            else begin
              for (int i = 0; i < int'(cif.cmd_count); i++) begin
                plan.push_back(P_T);
                if (i < int'(cif.cmd_count) - 1) repeat (int'(cif.cmd_gap)) plan.push_back(P_G);
              end
              plan.push_back(P_D);
            end
          end
        end else if (cif.abort && h != P_C) plan.delete();
        else void'(plan.pop_front());
      end
    end
  end
  initial begin
    int n, pat, dn;
    cif.cmd_valid = 1'b0;
    cif.cmd_clr   = 1'b0;
    cif.cmd_count = '0;
    cif.cmd_gap   = '0;
    cif.abort     = 1'b0;
    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_tff_rst", int'(tff_rst), 1);
    chk("rst_busy", int'(busy), 1);
    chk("rst_ready", int'(cif.cmd_ready), 0);
    rst_n = 1'b1;
    chk("clear_cycle", int'(tff_rst), 1);
    step();
    chk("idle_ready", int'(cif.cmd_ready), 1);
    send(1'b0, 3, 0);
    run(n, pat, dn);
    chk("c3g0_cycles", n, 4);
    chk("c3g0_tpat", pat, 'b1110);
    chk("c3g0_done", dn, 1);
    chk("c3g0_qexp", int'(q_exp), 1);
    chk("c3g0_q", int'(q_in), 1);
    chk("c3g0_mis", int'(mismatch), 0);
    send(1'b0, 2, 2);
    run(n, pat, dn);
    chk("c2g2_cycles", n, 5);
    chk("c2g2_tpat", pat, 'b10010);
    chk("c2g2_qexp", int'(q_exp), 1);
    send(1'b0, 0, 0);
    run(n, pat, dn);
    chk("c0_cycles", n, 1);
    chk("c0_tpat", pat, 0);
    chk("c0_done", dn, 1);
    chk("c0_ready", int'(cif.cmd_ready), 1);
    send(1'b1, 7, 5);
    chk("clr_tff_rst", int'(tff_rst), 1);
    step();
    chk("clr_qexp", int'(q_exp), 0);
    chk("clr_q", int'(q_in), 0);
    q_force = 1'b1;
    step();
    q_force = 1'b0;
    chk("force_mis", int'(mismatch), 1);
    step();
    step();
    step();
    chk("mis_sticky", int'(mismatch), 1);
    send(1'b1, 0, 0);
    step();
    chk("mis_cleared", int'(mismatch), 0);
    send(1'b0, 5, 1);
    step();
    step();
    chk("abort_on_t2", int'(t), 1);
    cif.abort = 1'b1;
    step();
    cif.abort = 1'b0;
    chk("abort_ready", int'(cif.cmd_ready), 1);
    chk("abort_t", int'(t), 0);
    chk("abort_qexp", int'(q_exp), 0);
    dn = 0;
    repeat (5) begin
      dn += int'(done);
      step();
    end
    chk("abort_no_done", dn, 0);
    send(1'b0, 4, 3);
    step();
    chk("gap_t", int'(t), 0);
    chk("gap_qexp", int'(q_exp), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_t", int'(t), 0);
    chk("midrst_tff_rst", int'(tff_rst), 1);
    chk("midrst_qexp", int'(q_exp), 0);
    step();
    step();
    rst_n = 1'b1;
    chk("post_rst_clear", int'(tff_rst), 1);
    chk("post_rst_ready", int'(cif.cmd_ready), 0);
    step();
    chk("post_rst_idle", int'(cif.cmd_ready), 1);
    send(1'b0, 1, 0);
    run(n, pat, dn);
    chk("c1_tpat", pat, 'b10);
    chk("c1_qexp", int'(q_exp), 1);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
